// File: rtl/div_share_arbiter.sv
// Round-robin share of one fixed_point_div (Q16.16 quotient) across NUM_REQ requesters.
// Optional divide-by-zero saturation guard: `DIV_SHARE_ARB_DZ_GUARD_EN.
module fixed_point_div (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [31:0] q
);

  logic signed [47:0] num;
  logic signed [47:0] den;
  logic signed [47:0] quo;

  // 48-bit working width keeps -32768/-1 well defined before truncation
  always_comb begin
    num = {{16{a[15]}}, a, 16'h0000};
    den = {{32{b[15]}}, b};
    quo = (b == 16'sd0) ? 48'sd0 : num / den;
    q   = quo[31:0];
  end

endmodule

module div_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DIV_LAT = 2,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [31:0]             resp_result,
  output logic                    resp_dz,
  output logic                    busy
);

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    idx;
  logic               found;
  logic [15:0]        sel_a;
  logic [15:0]        sel_b;
  logic               xfer;

  logic               op_v;
  logic [ID_W-1:0]    op_id;
  logic signed [15:0] op_a;
  logic signed [15:0] op_b;
  logic signed [31:0] div_q;
  logic [31:0]        st_res;
  logic               st_dz;

  logic [DIV_LAT-1:0] r_v;
  logic [DIV_LAT-1:0] r_dz;
  logic [ID_W-1:0]    r_id  [DIV_LAT];
  logic [31:0]        r_res [DIV_LAT];

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    if (found) grant[gnt_id] = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_id == ID_W'(k)) begin
        sel_a = req_a[16*k +: 16];
        sel_b = req_b[16*k +: 16];
      end
    end
  end

  assign req_ready = rst ? '0 : grant;
  assign xfer      = |req_ready;

  fixed_point_div u_div (
    .a (op_a),
    .b (op_b),
    .q (div_q)
  );

`ifdef DIV_SHARE_ARB_DZ_GUARD_EN
  assign st_dz  = (op_b == 16'sd0);
  assign st_res = !st_dz ? div_q :
                  op_a[15] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
  assign st_dz  = 1'b0;
  assign st_res = div_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      op_v   <= 1'b0;
      op_id  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      r_v    <= '0;
      r_dz   <= '0;
      for (int i = 0; i < DIV_LAT; i++) begin
        r_id[i]  <= '0;
        r_res[i] <= '0;
      end
    end else begin
      op_v <= xfer;
      if (xfer) begin
        op_id  <= gnt_id;
        op_a   <= sel_a;
        op_b   <= sel_b;
        rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
      r_v[0]   <= op_v;
      r_dz[0]  <= st_dz;
      r_id[0]  <= op_id;
      r_res[0] <= st_res;
      for (int i = 1; i < DIV_LAT; i++) begin
        r_v[i]   <= r_v[i-1];
        r_dz[i]  <= r_dz[i-1];
        r_id[i]  <= r_id[i-1];
        r_res[i] <= r_res[i-1];
      end
    end
  end

  assign resp_valid  = r_v[DIV_LAT-1];
  assign resp_id     = r_id[DIV_LAT-1];
  assign resp_result = r_res[DIV_LAT-1];
  assign resp_dz     = r_dz[DIV_LAT-1];
  assign busy        = op_v | (|r_v);

endmodule

// File: tb/tb_div_share_arbiter.sv
// Randomised bench for div_share_arbiter against a queue-based reference model.
// Build with +define+DIV_SHARE_ARB_DZ_GUARD_EN to cover the zero-divisor guard.
module tb_div_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DIV_LAT = 2;
  localparam int ID_W    = 2;
`ifdef DIV_SHARE_ARB_DZ_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [31:0] resp_result;
  logic        resp_dz;
  logic        busy;

  div_share_arbiter #(.NUM_REQ(NUM_REQ), .DIV_LAT(DIV_LAT), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_dz     (resp_dz),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] res;
    logic        dz;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   m_ptr = 0;
  int   last_g = -1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic signed [15:0] op_a [NUM_REQ];
  logic signed [15:0] op_b [NUM_REQ];
  logic [3:0]  obs_rdy, exp_rdy;
  logic        obs_v, exp_v, obs_busy, exp_busy, obs_dz, exp_dz;
  logic [1:0]  obs_id, exp_id;
  logic [31:0] obs_res, exp_res;

  // Q16.16 quotient: (a * 2^16) / b, truncated toward zero
  function automatic logic [31:0] ref_div(input logic signed [15:0] a,
                                          input logic signed [15:0] b);
    longint qv;
    if (b == 16'sd0) begin
      if (GUARD) return (a < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return 32'h0;
    end
    qv = (longint'(a) * 65536) / longint'(b);
    return qv[31:0];
  endfunction

  function automatic int ref_grant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic tick(input bit r, input logic [3:0] v);
    exp_t e;
    int   g;
    rst       = r;
    req_valid = v;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[16*i +: 16] = op_a[i];
      req_b[16*i +: 16] = op_b[i];
    end
    #1;
    obs_rdy = req_ready;
    g = r ? -1 : ref_grant(v, m_ptr);
    exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
    last_g = g;
    if (g >= 0) begin
      e.due = cyc + DIV_LAT + 1;
      e.id  = g;
      e.res = ref_div(op_a[g], op_b[g]);
      e.dz  = GUARD && (op_b[g] == 16'sd0);
      q.push_back(e);
      m_ptr = (g + 1) % NUM_REQ;
    end
    if (r) begin
      q.delete();
      m_ptr = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    obs_v    = resp_valid;
    obs_id   = resp_id;
    obs_res  = resp_result;
    obs_dz   = resp_dz;
    obs_busy = busy;
    exp_busy = (q.size() != 0);
    exp_v = 1'b0; exp_id = '0; exp_res = '0; exp_dz = 1'b0;
    if (q.size() != 0 && q[0].due == cyc) begin
      exp_v   = 1'b1;
      exp_id  = 2'(q[0].id);
      exp_res = q[0].res;
      exp_dz  = q[0].dz;
      void'(q.pop_front());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 4'b1111);
      n_chk++;
      if (obs_rdy !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ready got=%b want=0000", obs_rdy);
      end
    end
    n_chk++;
    if ({obs_v, obs_busy, obs_id, obs_res, obs_dz} !== 37'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b b=%b id=%0d r=%h dz=%b want all 0",
               obs_v, obs_busy, obs_id, obs_res, obs_dz);
    end
  endtask

  task automatic test_single();
    op_a[0] = 16'sd256;
    op_b[0] = 16'sd512;
    for (int t = 0; t < 5; t++) begin
      tick(1'b0, (t == 0) ? 4'b0001 : 4'b0000);
      n_chk++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL single_ready t=%0d got=%b want=%b", t, obs_rdy, exp_rdy);
      end
      n_chk++;
      if ({obs_v, obs_busy} !== {exp_v, exp_busy} ||
          (exp_v && {obs_id, obs_res, obs_dz} !== {exp_id, exp_res, exp_dz})) begin
        n_fail++;
        $display("FAIL single_resp t=%0d got v=%b b=%b id=%0d r=%h want v=%b b=%b id=%0d r=%h",
                 t, obs_v, obs_busy, obs_id, obs_res, exp_v, exp_busy, exp_id, exp_res);
      end
      if (t == 2) begin
        n_chk++;
        if (obs_v !== 1'b1 || obs_res !== 32'h0000_8000) begin
          n_fail++;
          $display("FAIL single_value got v=%b r=%h want v=1 r=00008000", obs_v, obs_res);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    tick(1'b1, 4'b0000);
    for (int t = 0; t < 18; t++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        op_a[i] = 16'($urandom);
        op_b[i] = 16'($urandom_range(1, 32767));
      end
      tick(1'b0, (t < 8) ? 4'b1111 : (t < 12) ? 4'b0100 : 4'b0000);
      n_chk++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL rr_ready t=%0d got=%b want=%b", t, obs_rdy, exp_rdy);
      end
      n_chk++;
      if ({obs_v, obs_busy} !== {exp_v, exp_busy} ||
          (exp_v && {obs_id, obs_res, obs_dz} !== {exp_id, exp_res, exp_dz})) begin
        n_fail++;
        $display("FAIL rr_resp t=%0d got v=%b b=%b id=%0d r=%h want v=%b b=%b id=%0d r=%h",
                 t, obs_v, obs_busy, obs_id, obs_res, exp_v, exp_busy, exp_id, exp_res);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] pat [6];
    pat = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
    tick(1'b1, 4'b0000);
    for (int t = 0; t < 8; t++) begin
      tick(1'b0, (t < 6) ? pat[t] : 4'b0000);
      n_chk++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL wrap_ready t=%0d got=%b want=%b", t, obs_rdy, exp_rdy);
      end
      n_chk++;
      if ({obs_v, obs_busy} !== {exp_v, exp_busy} ||
          (exp_v && {obs_id, obs_res} !== {exp_id, exp_res})) begin
        n_fail++;
        $display("FAIL wrap_resp t=%0d got v=%b id=%0d r=%h want v=%b id=%0d r=%h",
                 t, obs_v, obs_id, obs_res, exp_v, exp_id, exp_res);
      end
    end
  endtask

  task automatic test_reset_mid();
    op_a[3] = 16'sd1000;
    op_b[3] = 16'sd7;
    tick(1'b1, 4'b0000);
    tick(1'b0, 4'b1000);
    tick(1'b1, 4'b1000);
    for (int t = 0; t < 6; t++) begin
      tick(1'b0, (t == 5) ? 4'b1111 : 4'b0000);
      n_chk++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL rstmid_ready t=%0d got=%b want=%b", t, obs_rdy, exp_rdy);
      end
      n_chk++;
      if (obs_v !== 1'b0 || obs_busy !== exp_busy) begin
        n_fail++;
        $display("FAIL rstmid_resp t=%0d got v=%b b=%b want v=0 b=%b",
                 t, obs_v, obs_busy, exp_busy);
      end
    end
    tick(1'b1, 4'b0000);
  endtask

  task automatic test_drop();
    tick(1'b1, 4'b0000);
    op_a[0] = -16'sd300;
    op_b[0] = 16'sd9;
    for (int t = 0; t < 5; t++) begin
      tick(1'b0, (t == 0) ? 4'b0101 : 4'b0000);
      n_chk++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL drop_ready t=%0d got=%b want=%b", t, obs_rdy, exp_rdy);
      end
      n_chk++;
      if ({obs_v, obs_busy} !== {exp_v, exp_busy} ||
          (exp_v && {obs_id, obs_res} !== {exp_id, exp_res})) begin
        n_fail++;
        $display("FAIL drop_resp t=%0d got v=%b id=%0d r=%h want v=%b id=%0d r=%h",
                 t, obs_v, obs_id, obs_res, exp_v, exp_id, exp_res);
      end
    end
  endtask

  task automatic test_div_zero();
    op_a[1] = -16'sd100;
    op_b[1] = 16'sd0;
    op_a[2] = 16'sd100;
    op_b[2] = 16'sd0;
    for (int t = 0; t < 6; t++) begin
      tick(1'b0, (t == 0) ? 4'b0010 : (t == 1) ? 4'b0100 : 4'b0000);
      n_chk++;
      if ({obs_v, obs_busy} !== {exp_v, exp_busy} ||
          (exp_v && {obs_id, obs_res, obs_dz} !== {exp_id, exp_res, exp_dz})) begin
        n_fail++;
        $display("FAIL dz_resp t=%0d got v=%b id=%0d r=%h dz=%b want v=%b id=%0d r=%h dz=%b",
                 t, obs_v, obs_id, obs_res, obs_dz, exp_v, exp_id, exp_res, exp_dz);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = 16'($urandom);
      op_b[i] = 16'($urandom);
    end
    for (int t = 0; t < 300; t++) begin
      tick($urandom_range(0, 49) == 0, 4'($urandom_range(0, 15)));
      if (last_g >= 0) begin
        op_a[last_g] = 16'($urandom);
        op_b[last_g] = ($urandom_range(0, 7) == 0) ? 16'sd0 : 16'($urandom);
      end
      n_chk++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready t=%0d got=%b want=%b", t, obs_rdy, exp_rdy);
      end
      n_chk++;
      if ({obs_v, obs_busy} !== {exp_v, exp_busy} ||
          (exp_v && {obs_id, obs_res, obs_dz} !== {exp_id, exp_res, exp_dz})) begin
        n_fail++;
        $display("FAIL rand_resp t=%0d got v=%b b=%b id=%0d r=%h dz=%b want v=%b b=%b id=%0d r=%h dz=%b",
                 t, obs_v, obs_busy, obs_id, obs_res, obs_dz,
                 exp_v, exp_busy, exp_id, exp_res, exp_dz);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = '0;
      op_b[i] = 16'sd1;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_drop();
    test_div_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
